// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship repair rooms.
package nexys_starship_pkg;

    // Room controller states, shared by the left, top and bottom repair machines
    typedef enum logic [1:0] {
        LR_INIT    = 2'd0,
        LR_WORKING = 2'd1,
        LR_REPAIR  = 2'd2
    } lr_state_e;

    // Default repair budget: timer ticks before timeout, wrong submits before failure
    localparam int REPAIR_TIMEOUT_TICKS = 10;
    localparam int REPAIR_MAX_WRONG     = 3;

    // Choose the code to issue. If the PRNG value already matches the switches,
    // issue its inverse so the player can never solve the room without acting.
    function automatic logic [3:0] repair_code(input logic [3:0] randomHex,
                                               input logic [3:0] switchHex);
        logic [3:0] code;
        code = randomHex;
        if (randomHex == switchHex) begin
            code = ~randomHex;
        end
        return code;
    endfunction

endpackage

// File: rtl/nexys_starship_tick_sync.sv
// Brings the slow divided timer clock into the system clock domain and
// turns each of its rising edges into a one-cycle tick pulse.
module nexys_starship_tick_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic tick_o
);

    logic sync0_q;
    logic sync1_q;
    logic sync2_q;

    // Two-flop synchronizer followed by one history flop for edge detection
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync0_q <= async_i;
            sync1_q <= sync0_q;
            sync2_q <= sync1_q;
        end
    end

    // Rising edge of the synchronized level, high for exactly one clock
    assign tick_o = sync1_q & ~sync2_q;

endmodule

// File: rtl/nexys_starship_lr.sv
// Left-room repair responder: issues a repair code when the PRNG breaks the
// room, checks submitted switch combos, and flags gameover on too many wrong
// answers or when the repair timer runs out.
module nexys_starship_lr
    import nexys_starship_pkg::*;
#(
    parameter int TIMEOUT_TICKS = REPAIR_TIMEOUT_TICKS,
    parameter int MAX_WRONG     = REPAIR_MAX_WRONG
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic       timer_clk,
    input  logic       LR_random,
    input  logic [3:0] random_hex,
    input  logic [3:0] hex_combo,
    input  logic       BtnL,
    output logic       q_LR_Init,
    output logic       q_LR_Working,
    output logic       q_LR_Repair,
    output logic       left_broken,
    output logic [3:0] LR_combo,
    output logic       left_gameover,
    output logic [3:0] LR_time_left
);

    localparam int                 WRONG_W     = $clog2(MAX_WRONG + 1);
    localparam logic [WRONG_W-1:0] WRONG_LIMIT = WRONG_W'(MAX_WRONG);
    localparam logic [3:0]         TIME_INIT   = 4'(TIMEOUT_TICKS);

    lr_state_e          state_q,    state_d;
    logic               broken_q,   broken_d;
    logic [3:0]         combo_q,    combo_d;
    logic               gameover_q, gameover_d;
    logic [3:0]         time_q,     time_d;
    logic [WRONG_W-1:0] wrong_q,    wrong_d;
    logic [WRONG_W-1:0] wrongInc;
    logic               tick;

    nexys_starship_tick_sync u_tick_sync (
        .clk_i   (Clk),
        .reset_i (Reset),
        .async_i (timer_clk),
        .tick_o  (tick)
    );

    // State and status registers; reset puts the room back to an idle INIT
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= LR_INIT;
            broken_q   <= 1'b0;
            combo_q    <= 4'h0;
            gameover_q <= 1'b0;
            time_q     <= TIME_INIT;
            wrong_q    <= '0;
        end else begin
            state_q    <= state_d;
            broken_q   <= broken_d;
            combo_q    <= combo_d;
            gameover_q <= gameover_d;
            time_q     <= time_d;
            wrong_q    <= wrong_d;
        end
    end

    // Next-state logic: break on a PRNG tick, then resolve the repair by a
    // global abort, a correct submit, too many wrong submits, or timeout
    always_comb begin
        state_d    = state_q;
        broken_d   = broken_q;
        combo_d    = combo_q;
        gameover_d = gameover_q;
        time_d     = time_q;
        wrong_d    = wrong_q;
        wrongInc   = (wrong_q == WRONG_LIMIT) ? wrong_q : wrong_q + WRONG_W'(1);

        case (state_q)
            LR_INIT: begin
                wrong_d  = '0;
                broken_d = 1'b0;
                if (play_flag && !gameover_ctrl) begin
                    state_d = LR_WORKING;
                end
            end

            LR_WORKING: begin
                if (gameover_ctrl) begin
                    state_d = LR_INIT;
                end else if (tick && LR_random) begin
                    state_d  = LR_REPAIR;
                    combo_d  = repair_code(random_hex, hex_combo);
                    time_d   = TIME_INIT;
                    wrong_d  = '0;
                    broken_d = 1'b1;
                end
            end

            LR_REPAIR: begin
                if (gameover_ctrl) begin
                    state_d  = LR_INIT;
                    broken_d = 1'b0;
                end else if (BtnL && (hex_combo == combo_q)) begin
                    state_d  = LR_WORKING;
                    broken_d = 1'b0;
                end else if (BtnL) begin
                    wrong_d = wrongInc;
                    if (wrongInc == WRONG_LIMIT) begin
                        gameover_d = 1'b1;
                        state_d    = LR_INIT;
                        broken_d   = 1'b0;
                    end
                end else if (tick) begin
                    if (time_q != 4'd0) begin
                        time_d = time_q - 4'd1;
                    end
                    if (time_q == 4'd1) begin
                        gameover_d = 1'b1;
                        state_d    = LR_INIT;
                        broken_d   = 1'b0;
                    end
                end
            end

            default: begin
                state_d = LR_INIT;
            end
        endcase
    end

    assign q_LR_Init     = (state_q == LR_INIT);
    assign q_LR_Working  = (state_q == LR_WORKING);
    assign q_LR_Repair   = (state_q == LR_REPAIR);
    assign left_broken   = broken_q;
    assign LR_combo      = combo_q;
    assign left_gameover = gameover_q;
    assign LR_time_left  = time_q;

endmodule

// File: doc/nexys_starship_lr.md
# nexys_starship_LR

Left-room repair responder for Nexys Starship. It receives the player's switch combo (`hex_combo`) and left-button submit pulses, and checks them against a randomly issued repair code. It drives the left-room broken/gameover status back to the game controller and the VGA block. It sits beside the existing top/bottom repair machines, is fed by the PRNG (`LR_random`, `random_hex`), and runs on `sys_clk`.

## Interface
Parameters:
- `TIMEOUT_TICKS`, default 10: timer ticks allowed to repair before gameover.
- `MAX_WRONG`, default 3: wrong submissions that cause gameover.

Ports. Clock is `Clk`. Reset is `Reset`: one clock; reset is synchronous and active-high.
- `Clk` in 1: system clock, 100 MHz.
- `Reset` in 1: synchronous, active-high.
- `play_flag` in 1: game is in Play.
- `gameover_ctrl` in 1: global gameover level.
- `timer_clk` in 1: slow divided clock (`DIV_CLK[24]`), asynchronous to sampling.
- `LR_random` in 1: PRNG break request.
- `random_hex` in 4: PRNG code.
- `hex_combo` in 4: registered switch value.
- `BtnL` in 1: debounced single-cycle submit pulse.
- `q_LR_Init`, `q_LR_Working`, `q_LR_Repair` out 1 each: one-hot state.
- `left_broken` out 1: room needs repair.
- `LR_combo` out 4: code to display.
- `left_gameover` out 1: sticky failure flag.
- `LR_time_left` out 4: remaining ticks, for the SSD.

## Operation
- **Tick:** `timer_clk` passes through a 2-flop synchronizer. A rising edge produces `tick`, high for exactly one `Clk`.
- **INIT:**
  - `play_flag`=1 and `gameover_ctrl`=0 → WORKING.
  - Clears `wrong_cnt` and `left_broken`.
- **WORKING:**
  - `gameover_ctrl`=1 → INIT.
  - Otherwise, on `tick` with `LR_random`=1 → REPAIR, and latch the code:
    - `LR_combo` ← `random_hex`.
    - If `random_hex` == `hex_combo`, latch `~random_hex` instead, so the current switches never pre-solve the code.
    - `LR_time_left` ← `TIMEOUT_TICKS`, `wrong_cnt` ← 0, `left_broken` ← 1.
- **REPAIR:**
  - Priority 1: `gameover_ctrl`=1 → INIT, `left_broken` ← 0.
  - Priority 2: `BtnL` with `hex_combo` == `LR_combo` → WORKING, `left_broken` ← 0.
  - Priority 3: `BtnL` with a mismatch → `wrong_cnt`+1. When it reaches `MAX_WRONG`, set `left_gameover` ← 1 and go to INIT.
  - Priority 4: `tick` → `LR_time_left`−1. Leaving 1→0 sets `left_gameover` ← 1 and goes to INIT.
  - A correct submit in the same cycle as the expiring tick is a repair; the timeout is ignored.
- **`left_gameover`:** cleared only by `Reset`.
- **Width rules:**
  - `wrong_cnt` is $clog2(`MAX_WRONG`+1) bits and saturates.
  - `LR_time_left` is 4 bits, so `TIMEOUT_TICKS` ≤ 15. It never decrements below 0.
- **`LR_combo`:** holds its last value outside REPAIR.

## Timing
- All outputs are registered. State and status change in cycle n+1 after the qualifying input in cycle n.
- Tick latency: from the `timer_clk` rising edge to the `tick` pulse is 2–3 `Clk` cycles.
- `LR_random` is sampled only in the `tick` cycle.
- Reset values:
  - `q_LR_Init`=1, `q_LR_Working`=0, `q_LR_Repair`=0.
  - `left_broken`=0, `LR_combo`=0, `left_gameover`=0.
  - `LR_time_left`=`TIMEOUT_TICKS`.
  - Synchronizer flops=0.
- `Reset` mid-REPAIR: INIT on the next edge, and all outputs return to their reset values.
- A `BtnL` pulse outside REPAIR is ignored.

## Structure
- Shared package `nexys_starship_pkg`:
  - State encoding `LR_INIT`, `LR_WORKING`, `LR_REPAIR`, reused by the other repair rooms.
  - Default constants `REPAIR_TIMEOUT_TICKS`=10 and `REPAIR_MAX_WRONG`=3.
- Sub-module `nexys_starship_tick_sync`: the `timer_clk` synchronizer and rising-edge detector. The monster and repair machines will reuse it.

## Test plan
- Reset, then `play_flag`=1 → `q_LR_Working`=1 at the next edge. With `LR_random`=1 and `random_hex`=4'hA on a tick → REPAIR, `LR_combo`=A, `left_broken`=1, `LR_time_left`=10.
- In REPAIR with `LR_combo`=A, `hex_combo`=A, `BtnL` pulse → WORKING one cycle later, `left_broken`=0, `left_gameover`=0.
- `random_hex`=5 while `hex_combo`=5 at the break → `LR_combo`=A (the inverse).
- Three `BtnL` pulses with `hex_combo`=3 against code A → `left_gameover`=1 after the third, state INIT. The flag stays high until `Reset`.
- No submit for 10 ticks → `LR_time_left` counts 10→0, `left_gameover`=1. A correct `BtnL` in the same cycle as the 10th tick → WORKING, no gameover.
- `gameover_ctrl`=1 during REPAIR with a simultaneous correct `BtnL` → INIT and `left_broken`=0. `Reset` asserted mid-REPAIR → all outputs at their reset values next cycle.
